// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    WAIT,
    FETCH,
    HALT
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs between the PC sequencer and decode.
// Latency: a push is visible at the head one clock later; the head is zero while empty.
// Backpressure: a push while full is accepted only together with a pop; flush empties it.
module fetch_buffer
  import ifu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head_dat,
  output logic         head_vld,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok   = pop && (count != 2'd0);
  assign push_ok  = push && ((count != 2'd2) || pop_ok);
  assign head_vld = (count != 2'd0);
  assign head_dat = head_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // A full-buffer push overwrites the slot being popped this same cycle.
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Owns the PC, reads the combinational instruction memory and queues results for decode.
// Latency: first instruction START_DELAY+1 clocks after reset; one per clock when decode is ready.
// Backpressure: PC stalls while the buffer is full; redirects flush it; misaligned targets halt.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                IMEM_BYTES  = 1024,
  parameter int                START_DELAY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_instruction,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst,
  output logic [ADDR_W-1:0]  inst_pc,
  output logic               misalign_err
);

  localparam logic [ADDR_W-1:0] PC_MASK    = ADDR_W'(IMEM_BYTES - 1);
  localparam int                DW         = (START_DELAY > 2) ? $clog2(START_DELAY) : 1;
  localparam logic [DW-1:0]     DELAY_LAST = (START_DELAY > 1) ? DW'(START_DELAY - 1) : '0;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [DW-1:0]     delay_cnt, delay_cnt_nxt;
  logic              err_nxt;
  logic              redirect_take;
  logic              push, pop, flush;
  logic [1:0]        buf_count;
  fetch_entry_t      push_dat, head_dat;

  assign imem_address  = fetch_pc;
  assign redirect_take = redirect_valid && (state != HALT);
  assign pop           = inst_valid && inst_ready && !redirect_take;
  assign push_dat.pc    = PC_W'(fetch_pc);
  assign push_dat.instr = imem_instruction;

  always_comb begin
    state_nxt     = state;
    fetch_pc_nxt  = fetch_pc;
    delay_cnt_nxt = delay_cnt;
    err_nxt       = misalign_err;
    push          = 1'b0;
    flush         = 1'b0;

    case (state)
      WAIT: begin
        if (delay_cnt == DELAY_LAST) begin
          state_nxt = FETCH;
        end else begin
          delay_cnt_nxt = delay_cnt + 1'b1;
        end
      end
      FETCH: begin
        push = (buf_count != 2'd2) || pop;
        if (push) begin
          fetch_pc_nxt = (fetch_pc + ADDR_W'(PC_STEP)) & PC_MASK;
        end
      end
      default: ;
    endcase

    // Redirect overrides sequencing; a misaligned target freezes the PC at its last good value.
    if (redirect_take) begin
      push  = 1'b0;
      flush = 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        state_nxt    = HALT;
        err_nxt      = 1'b1;
        fetch_pc_nxt = fetch_pc;
      end else begin
        fetch_pc_nxt = redirect_pc & PC_MASK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT;
      fetch_pc     <= RESET_PC;
      delay_cnt    <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      fetch_pc     <= fetch_pc_nxt;
      delay_cnt    <= delay_cnt_nxt;
      misalign_err <= err_nxt;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (flush),
    .head_dat (head_dat),
    .head_vld (inst_valid),
    .count    (buf_count)
  );

  assign inst    = head_dat.instr;
  assign inst_pc = ADDR_W'(head_dat.pc);

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. Owns the program counter and drives the word address into the combinational-read instruction memory. Captures each returned instruction with its PC into a 2-entry buffer and presents it to decode over a valid/ready handshake. Accepts branch/jump redirects from execute.

Parameters:
ADDR_W, 32, width of PC and memory address
RESET_PC, 0, byte address of the first fetch after reset
IMEM_BYTES, 1024, instruction memory size in bytes (power of 2); PC wraps modulo this value
START_DELAY, 1, cycles after reset release before the first fetch (memory load window)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
imem_address  output  ADDR_W  byte address to instruction memory
imem_instruction  input  32  instruction at imem_address, valid in the same cycle (combinational read)
redirect_valid  input  1  one-cycle request to change PC
redirect_pc  input  ADDR_W  target byte address
inst_valid  output  1  buffer head is valid
inst_ready  input  1  decode accepts head this cycle
inst  output  32  head instruction; 0 when empty
inst_pc  output  ADDR_W  head PC; 0 when empty
misalign_err  output  1  sticky misaligned-redirect flag

Behaviour:
- Reset (async assert, sync-released effect): fetch_pc=RESET_PC, buffer count=0, inst_valid=0, inst=0, inst_pc=0, misalign_err=0, state=WAIT, delay counter=0. imem_address=RESET_PC.
- imem_address is driven combinationally from fetch_pc in all states.
- State WAIT: the delay counter counts clocks. After START_DELAY cycles go to FETCH. Nothing is pushed. A redirect here updates fetch_pc and is subject to the same alignment check.
- State FETCH: push enabled when count<2, or when count==2 and a pop occurs in the same cycle.
  - On push, write {fetch_pc, imem_instruction} to the buffer tail.
  - fetch_pc <= (fetch_pc+4) mod IMEM_BYTES.
  - With no push, fetch_pc holds.
- Pop: occurs when inst_valid && inst_ready. Simultaneous push and pop keeps count unchanged.
- Redirect: highest priority in any state except HALT.
  - Buffer is flushed (count=0); no push and no pop in that cycle.
  - fetch_pc <= redirect_pc mod IMEM_BYTES.
  - inst_valid is 0 the next cycle. The first redirected instruction has inst_valid=1 two cycles after the redirect cycle.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - go to HALT, set misalign_err=1, flush the buffer, load no PC.
  - HALT is left only by reset. In HALT inst_valid=0, and imem_address holds the last aligned fetch_pc.
- Latency: in steady state with inst_ready=1, one instruction per cycle. First inst_valid occurs START_DELAY+1 cycles after reset release.
- Wrap: PC IMEM_BYTES-4 is followed by PC 0, with no error.
- Full buffer with inst_ready=0: fetch_pc and imem_address hold. No instruction is lost or duplicated.
- Reset mid-operation: all state returns to reset values immediately. In-flight buffer contents are discarded.

Decomposition:
- Package ifu_pkg:
  - state enum {WAIT, FETCH, HALT}
  - INSTR_W=32
  - PC_STEP=4
  - fetch-entry struct {pc, instr}
- One sub-module: fetch_buffer. It is a 2-entry synchronous FIFO of fetch entries with push/pop/flush, count, and head outputs, reset by rst_n.

Test Plan:
- Startup: memory holds 0x11,0x22,0x33 at 0,4,8; inst_ready=1; release reset -> inst_valid rises START_DELAY+1 cycles later. inst_pc sequence is 0,4,8 with inst 0x11,0x22,0x33 on consecutive cycles.
- Backpressure: inst_ready=0 for 5 cycles after the first valid -> count saturates at 2, imem_address holds at 8, inst_pc stays 0. Raise ready -> 0,4,8 are delivered with no gap or duplicate.
- Redirect while full: buffer holds PCs 0,4; redirect_pc=0x40 -> next cycle inst_valid=0. Two cycles after the redirect, inst_pc=0x40 with mem[0x40].
- Misaligned redirect: redirect_pc=0x42 -> misalign_err=1 and inst_valid=0 from the next cycle. Further redirects are ignored until rst_n pulse.
- Wrap: IMEM_BYTES=64, run past PC 60 -> next inst_pc is 0, misalign_err stays 0.
- Mid-run reset: assert rst_n=0 at PC 0x20 -> inst_valid=0 and imem_address=RESET_PC immediately, and the startup sequence repeats.
